// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the seven-segment scan driver: active-low cathode codes for hex 0-F.
package seven_seg_scan_pkg;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Frame-load and display-drive signals between the digit producer and the scan driver.
interface seven_seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dig_en;
  logic [NUM_DIGITS-1:0]     dp;
  logic [7:0]                ca;
  logic [NUM_DIGITS-1:0]     an;
  logic                      pend;

  modport master (output load, digits, dig_en, dp, input ca, an, pend);
  modport slave  (input load, digits, dig_en, dp, output ca, an, pend);
endinterface

// File: rtl/seven_seg_scan_hex_to_seg.sv
// Combinational hex nibble to active-low g..a segment decoder.
module seven_seg_scan_hex_to_seg
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  logic [7:0] code;

  always_comb begin
    code = SEG_OFF;
    unique case (nibble)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
      default: code = SEG_OFF;
    endcase
  end

  assign seg_c = code[6:0];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 7-segment driver with tear-free frame swap at scan wrap.
// Optional decimal-point support is enabled by defining SSD_DP_EN.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned REFRESH_CYCLES = 10000,
  parameter int unsigned BLANK_CYCLES   = 0
) (
  input  logic              clk,
  input  logic              rst,
  seven_seg_scan_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DIG_W-1:0]      act_digits, pnd_digits;
  logic [NUM_DIGITS-1:0] act_en, pnd_en;
  logic                  pend;
  logic [7:0]            ca;
  logic [NUM_DIGITS-1:0] an;

  logic                  slot_end_c, wrap_c, blank_c, show_c, dp_bit_c;
  logic [3:0]            nibble_c;
  logic [6:0]            seg_c;

  assign slot_end_c = (cnt == CNT_W'(REFRESH_CYCLES - 1));
  assign wrap_c     = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
  assign nibble_c   = act_digits[{idx, 2'b00} +: 4];

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign blank_c = 1'b0;
    end else begin : g_blank
      assign blank_c = (cnt < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  assign show_c = act_en[idx] && !blank_c;

`ifdef SSD_DP_EN
  logic [NUM_DIGITS-1:0] act_dp, pnd_dp;

  // Decimal point travels with the frame so it swaps atomically with the digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_dp <= '0;
      pnd_dp <= '0;
    end else if (bus.load) begin
      if (wrap_c) act_dp <= bus.dp;
      else        pnd_dp <= bus.dp;
    end else if (wrap_c && pend) begin
      act_dp <= pnd_dp;
    end
  end

  assign dp_bit_c = ~act_dp[idx];
`else
  logic unused_dp;
  assign unused_dp = ^bus.dp;
  assign dp_bit_c  = 1'b1;
`endif

  seven_seg_scan_hex_to_seg u_dec (
    .nibble (nibble_c),
    .seg_c  (seg_c)
  );

  // Slot and digit-index counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // LOAD on the wrap edge bypasses the pending buffer and drops any stale pending frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_digits <= '0;
      act_en     <= '0;
      pnd_digits <= '0;
      pnd_en     <= '0;
      pend       <= 1'b0;
    end else if (bus.load) begin
      if (wrap_c) begin
        act_digits <= bus.digits;
        act_en     <= bus.dig_en;
        pend       <= 1'b0;
      end else begin
        pnd_digits <= bus.digits;
        pnd_en     <= bus.dig_en;
        pend       <= 1'b1;
      end
    end else if (wrap_c && pend) begin
      act_digits <= pnd_digits;
      act_en     <= pnd_en;
      pend       <= 1'b0;
    end
  end

  // Registered display drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ca <= SEG_OFF;
      an <= '1;
    end else if (show_c) begin
      ca <= {dp_bit_c, seg_c};
      an <= ~(NUM_DIGITS'(1) << idx);
    end else begin
      ca <= SEG_OFF;
      an <= '1;
    end
  end

  assign bus.ca   = ca;
  assign bus.an   = an;
  assign bus.pend = pend;

endmodule
